// File: rtl/accel_axi_mst.sv
// AXI4 burst master bridge: turns single-outstanding engine requests and write
// streams into INCR bursts, and returns read beats / write completions to the engine.
package accel_axi_pkg;
  localparam int CFG_SYSBUS_ADDR_BITS  = 32;
  localparam int CFG_SYSBUS_DATA_BITS  = 64;
  localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;
  localparam int CFG_SYSBUS_ID_BITS    = 5;
  localparam int CFG_SYSBUS_USER_BITS  = 1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } axi4_metadata_type;

  typedef struct packed {
    logic                             aw_valid;
    axi4_metadata_type                aw_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
    logic                             w_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
    logic                             w_last;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
    logic [CFG_SYSBUS_USER_BITS-1:0]  w_user;
    logic                             b_ready;
    logic                             ar_valid;
    axi4_metadata_type                ar_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
    logic                             r_ready;
  } axi4_master_out_type;

  typedef struct packed {
    logic                             aw_ready;
    logic                             w_ready;
    logic                             b_valid;
    logic [1:0]                       b_resp;
    logic [CFG_SYSBUS_ID_BITS-1:0]    b_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  b_user;
    logic                             ar_ready;
    logic                             r_valid;
    logic [1:0]                       r_resp;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  r_data;
    logic                             r_last;
    logic [CFG_SYSBUS_ID_BITS-1:0]    r_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  r_user;
  } axi4_master_in_type;
endpackage

module accel_axi_mst
  import accel_axi_pkg::*;
#(
  parameter logic [CFG_SYSBUS_ID_BITS-1:0] xid = '0,
  parameter int burst_max = 16
) (
  input  logic                             i_clk,
  input  logic                             i_nrst,
  output axi4_master_out_type              o_xmsto,
  input  axi4_master_in_type               i_xmsti,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic                             i_req_write,
  input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
  input  logic [7:0]                       i_req_len,
  input  logic                             i_wdata_valid,
  input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_wdata,
  input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_wstrb,
  output logic                             o_wdata_ready,
  output logic                             o_resp_valid,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata,
  output logic                             o_resp_last,
  output logic                             o_resp_err,
  input  logic                             i_resp_ready
);

  localparam int SIZE_LOG2 = $clog2(CFG_SYSBUS_DATA_BYTES);
  localparam logic [8:0] BURST_MAX_W = 9'(burst_max);

  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B, ST_ERR} state_t;

  state_t                          state_reg, state_next;
  logic [CFG_SYSBUS_ADDR_BITS-1:0] addr_reg, addr_next;
  logic [7:0]                      len_reg, len_next;
  logic                            write_reg, write_next;
  logic [7:0]                      cnt_reg, cnt_next;

  logic [13:0] end_off;
  logic        req_reject;
  logic        unused_in;

  // Byte offset just past the burst inside its 4 KB page; beyond 4096 means a crossing.
  assign end_off    = {2'b00, i_req_addr[11:0]} + (14'({1'b0, i_req_len} + 9'd1) << SIZE_LOG2);
  assign req_reject = ({1'b0, i_req_len} >= BURST_MAX_W) || (end_off > 14'd4096);
  assign unused_in  = ^{i_xmsti.b_id, i_xmsti.b_user, i_xmsti.r_id, i_xmsti.r_user,
                        i_xmsti.b_resp[0], i_xmsti.r_resp[0]};

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      len_reg   <= '0;
      write_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      write_reg <= write_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    write_next = write_reg;
    cnt_next   = cnt_reg;

    o_xmsto               = '0;
    o_xmsto.ar_bits.addr  = addr_reg;
    o_xmsto.ar_bits.len   = len_reg;
    o_xmsto.ar_bits.size  = 3'(SIZE_LOG2);
    o_xmsto.ar_bits.burst = AXI_BURST_INCR;
    o_xmsto.ar_id         = xid;
    o_xmsto.aw_bits       = o_xmsto.ar_bits;
    o_xmsto.aw_id         = xid;
    o_xmsto.w_data        = i_wdata;
    o_xmsto.w_strb        = i_wstrb;

    o_req_ready   = 1'b0;
    o_wdata_ready = 1'b0;
    o_resp_valid  = 1'b0;
    o_resp_rdata  = '1;
    o_resp_last   = 1'b0;
    o_resp_err    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          addr_next  = i_req_addr;
          len_next   = i_req_len;
          write_next = i_req_write;
          if (req_reject)       state_next = ST_ERR;
          else if (i_req_write) state_next = ST_AW;
          else                  state_next = ST_AR;
        end
      end
      ST_AR: begin
        o_xmsto.ar_valid = 1'b1;
        if (i_xmsti.ar_ready) state_next = ST_R;
      end
      ST_R: begin
        o_xmsto.r_ready = i_resp_ready;
        o_resp_valid    = i_xmsti.r_valid;
        o_resp_rdata    = i_xmsti.r_data;
        o_resp_last     = i_xmsti.r_last;
        o_resp_err      = i_xmsti.r_resp[1];
        // Error beats are delivered but do not cut the burst short.
        if (i_xmsti.r_valid && i_resp_ready && i_xmsti.r_last) state_next = ST_IDLE;
      end
      ST_AW: begin
        o_xmsto.aw_valid = 1'b1;
        if (i_xmsti.aw_ready) begin
          cnt_next   = len_reg;
          state_next = ST_W;
        end
      end
      ST_W: begin
        o_xmsto.w_valid = i_wdata_valid;
        o_xmsto.w_last  = (cnt_reg == 8'd0);
        o_wdata_ready   = i_xmsti.w_ready;
        if (i_wdata_valid && i_xmsti.w_ready) begin
          if (cnt_reg == 8'd0) state_next = ST_B;
          else                 cnt_next   = cnt_reg - 8'd1;
        end
      end
      ST_B: begin
        o_xmsto.b_ready = i_resp_ready;
        o_resp_valid    = i_xmsti.b_valid;
        o_resp_last     = 1'b1;
        o_resp_err      = i_xmsti.b_resp[1];
        if (i_xmsti.b_valid && i_resp_ready) state_next = ST_IDLE;
      end
      ST_ERR: begin
        o_resp_valid = 1'b1;
        o_resp_last  = 1'b1;
        o_resp_err   = 1'b1;
        if (i_resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_accel_axi_mst.sv
// Directed bench for accel_axi_mst: a request table plus hand-written multi-cycle sequences.
module tb_accel_axi_mst;
  import accel_axi_pkg::*;

  logic                             i_clk = 1'b0;
  logic                             i_nrst;
  axi4_master_out_type              xmsto;
  axi4_master_in_type               xmsti;
  logic                             i_req_valid;
  logic                             o_req_ready;
  logic                             i_req_write;
  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr;
  logic [7:0]                       i_req_len;
  logic                             i_wdata_valid;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_wdata;
  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_wstrb;
  logic                             o_wdata_ready;
  logic                             o_resp_valid;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata;
  logic                             o_resp_last;
  logic                             o_resp_err;
  logic                             i_resp_ready;

  always #5 i_clk = ~i_clk;

  accel_axi_mst #(.xid(5'd3), .burst_max(16)) dut (
    .i_clk         (i_clk),
    .i_nrst        (i_nrst),
    .o_xmsto       (xmsto),
    .i_xmsti       (xmsti),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_write   (i_req_write),
    .i_req_addr    (i_req_addr),
    .i_req_len     (i_req_len),
    .i_wdata_valid (i_wdata_valid),
    .i_wdata       (i_wdata),
    .i_wstrb       (i_wstrb),
    .o_wdata_ready (o_wdata_ready),
    .o_resp_valid  (o_resp_valid),
    .o_resp_rdata  (o_resp_rdata),
    .o_resp_last   (o_resp_last),
    .o_resp_err    (o_resp_err),
    .i_resp_ready  (i_resp_ready)
  );

  int n_err = 0;
  int n_chk = 0;

  // Handshake observers: counted on the clock edge, read back only as deltas.
  int mon_w_beats = 0;
  int mon_w_lasts = 0;
  int mon_resps   = 0;
  int mon_addr    = 0;

  always @(posedge i_clk) begin
    if (i_nrst) begin
      if (xmsto.w_valid && xmsti.w_ready) begin
        mon_w_beats <= mon_w_beats + 1;
        if (xmsto.w_last) mon_w_lasts <= mon_w_lasts + 1;
      end
      if (o_resp_valid && i_resp_ready) mon_resps <= mon_resps + 1;
      if (xmsto.ar_valid || xmsto.aw_valid) mon_addr <= mon_addr + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a, input int b);
    return {32'hCAFE_0000 + 32'(b), a};
  endfunction

  task automatic clear_slave();
    xmsti = '0;
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = addr;
    i_req_len   = len;
    #1 chk("req_ready_idle", 64'(o_req_ready), 64'd1);
    @(negedge i_clk);
    i_req_valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        exp_rej;
    int          exp_wbeats;
    int          exp_resps;
    int          exp_addr_cyc;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int w0, r0, a0;
    w0 = mon_w_beats;
    r0 = mon_resps;
    a0 = mon_addr;
    $display("txn wr=%0d addr=%h len=%0d exp_rej=%0d", v.wr, v.addr, v.len, v.exp_rej);
    do_req(v.wr, v.addr, v.len);
    if (v.exp_rej) begin
      i_wdata_valid = 1'b1;
      xmsti.w_ready = 1'b1;
      #1;
      chk("rej_valid", 64'(o_resp_valid), 64'd1);
      chk("rej_err", 64'(o_resp_err), 64'd1);
      chk("rej_last", 64'(o_resp_last), 64'd1);
      chk("rej_rdata", o_resp_rdata, '1);
      chk("rej_no_addr", 64'(xmsto.ar_valid | xmsto.aw_valid), 64'd0);
      chk("rej_wready", 64'(o_wdata_ready), 64'd0);
      i_resp_ready = 1'b1;
      @(negedge i_clk);
      i_resp_ready  = 1'b0;
      i_wdata_valid = 1'b0;
      clear_slave();
    end else if (!v.wr) begin
      #1;
      chk("ar_valid", 64'(xmsto.ar_valid), 64'd1);
      chk("ar_addr", 64'(xmsto.ar_bits.addr), 64'(v.addr));
      chk("ar_len", 64'(xmsto.ar_bits.len), 64'(v.len));
      chk("ar_size", 64'(xmsto.ar_bits.size), 64'd3);
      chk("ar_burst", 64'(xmsto.ar_bits.burst), 64'd1);
      chk("ar_id", 64'(xmsto.ar_id), 64'd3);
      xmsti.ar_ready = 1'b1;
      @(negedge i_clk);
      xmsti.ar_ready = 1'b0;
      for (int b = 0; b <= int'(v.len); b++) begin
        xmsti.r_valid = 1'b1;
        xmsti.r_data  = pat(v.addr, b);
        xmsti.r_last  = (b == int'(v.len));
        xmsti.r_resp  = 2'b00;
        i_resp_ready  = 1'b1;
        #1;
        chk("r_ready", 64'(xmsto.r_ready), 64'd1);
        chk("r_resp_valid", 64'(o_resp_valid), 64'd1);
        chk("r_rdata", o_resp_rdata, pat(v.addr, b));
        chk("r_last", 64'(o_resp_last), 64'(b == int'(v.len)));
        chk("r_err", 64'(o_resp_err), 64'd0);
        @(negedge i_clk);
      end
      clear_slave();
      i_resp_ready = 1'b0;
    end else begin
      #1;
      chk("aw_valid", 64'(xmsto.aw_valid), 64'd1);
      chk("aw_addr", 64'(xmsto.aw_bits.addr), 64'(v.addr));
      chk("aw_len", 64'(xmsto.aw_bits.len), 64'(v.len));
      chk("aw_size", 64'(xmsto.aw_bits.size), 64'd3);
      xmsti.aw_ready = 1'b1;
      @(negedge i_clk);
      xmsti.aw_ready = 1'b0;
      xmsti.w_ready  = 1'b1;
      for (int b = 0; b <= int'(v.len); b++) begin
        i_wdata_valid = 1'b1;
        i_wdata       = pat(v.addr, b);
        i_wstrb       = 8'hFF;
        #1;
        chk("w_valid", 64'(xmsto.w_valid), 64'd1);
        chk("w_data", xmsto.w_data, pat(v.addr, b));
        chk("w_last", 64'(xmsto.w_last), 64'(b == int'(v.len)));
        chk("wdata_ready", 64'(o_wdata_ready), 64'd1);
        @(negedge i_clk);
      end
      #1;
      chk("extra_beat_ready", 64'(o_wdata_ready), 64'd0);
      chk("extra_beat_wvalid", 64'(xmsto.w_valid), 64'd0);
      i_wdata_valid = 1'b0;
      xmsti.b_valid = 1'b1;
      xmsti.b_resp  = 2'b00;
      i_resp_ready  = 1'b1;
      #1;
      chk("b_ready", 64'(xmsto.b_ready), 64'd1);
      chk("b_resp_valid", 64'(o_resp_valid), 64'd1);
      chk("b_last", 64'(o_resp_last), 64'd1);
      chk("b_err", 64'(o_resp_err), 64'd0);
      chk("b_rdata", o_resp_rdata, '1);
      @(negedge i_clk);
      clear_slave();
      i_resp_ready = 1'b0;
    end
    #1;
    chk("req_ready_back", 64'(o_req_ready), 64'd1);
    chk("w_beat_count", 64'(mon_w_beats - w0), 64'(v.exp_wbeats));
    chk("resp_count", 64'(mon_resps - r0), 64'(v.exp_resps));
    chk("addr_cycles", 64'(mon_addr - a0), 64'(v.exp_addr_cyc));
  endtask

  vec_t vecs[8];

  initial begin
    int w0, r0, a0;

    vecs[0] = '{1'b0, 32'h0000_1000, 8'd0,  1'b0, 0,  1, 1};
    vecs[1] = '{1'b1, 32'h0000_2000, 8'd3,  1'b0, 4,  1, 1};
    vecs[2] = '{1'b0, 32'h0000_0FF8, 8'd1,  1'b1, 0,  1, 0};
    vecs[3] = '{1'b1, 32'h0000_3000, 8'd20, 1'b1, 0,  1, 0};
    vecs[4] = '{1'b0, 32'h0000_0FC0, 8'd7,  1'b0, 0,  8, 1};
    vecs[5] = '{1'b1, 32'h0000_5000, 8'd15, 1'b0, 16, 1, 1};
    vecs[6] = '{1'b0, 32'h0000_4000, 8'd16, 1'b1, 0,  1, 0};
    vecs[7] = '{1'b1, 32'h0000_1FF8, 8'd0,  1'b0, 1,  1, 1};

    // Reset with every slave/engine strobe high: no valid/ready may leak out.
    i_nrst        = 1'b0;
    i_req_valid   = 1'b0;
    i_req_write   = 1'b0;
    i_req_addr    = '0;
    i_req_len     = '0;
    i_wdata       = '0;
    i_wstrb       = '0;
    i_wdata_valid = 1'b1;
    i_resp_ready  = 1'b1;
    xmsti         = '0;
    xmsti.r_valid = 1'b1;
    xmsti.b_valid = 1'b1;
    xmsti.w_ready = 1'b1;
    #12;
    chk("rst_ar_valid", 64'(xmsto.ar_valid), 64'd0);
    chk("rst_aw_valid", 64'(xmsto.aw_valid), 64'd0);
    chk("rst_w_valid", 64'(xmsto.w_valid), 64'd0);
    chk("rst_r_b_ready", 64'(xmsto.r_ready | xmsto.b_ready), 64'd0);
    chk("rst_wdata_ready", 64'(o_wdata_ready), 64'd0);
    chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    @(negedge i_clk);
    i_nrst        = 1'b1;
    i_wdata_valid = 1'b0;
    i_resp_ready  = 1'b0;
    clear_slave();
    #1 chk("rst_req_ready", 64'(o_req_ready), 64'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Read with ar_ready arriving on the third address cycle.
    $display("txn seq read len=0 @1000 slow ar_ready");
    a0 = mon_addr;
    r0 = mon_resps;
    do_req(1'b0, 32'h0000_1000, 8'd0);
    #1 chk("slow_ar_c1", 64'(xmsto.ar_valid), 64'd1);
    @(negedge i_clk);
    #1 chk("slow_ar_c2_addr", 64'(xmsto.ar_bits.addr), 64'h1000);
    @(negedge i_clk);
    xmsti.ar_ready = 1'b1;
    #1 chk("slow_ar_c3", 64'(xmsto.ar_valid), 64'd1);
    @(negedge i_clk);
    xmsti.ar_ready = 1'b0;
    #1 chk("slow_ar_drop", 64'(xmsto.ar_valid), 64'd0);
    chk("slow_ar_cycles", 64'(mon_addr - a0), 64'd3);
    xmsti.r_valid = 1'b1;
    xmsti.r_data  = 64'h1122_3344_5566_7788;
    xmsti.r_last  = 1'b1;
    i_resp_ready  = 1'b1;
    #1;
    chk("slow_rdata", o_resp_rdata, 64'h1122_3344_5566_7788);
    chk("slow_last_err", 64'({o_resp_last, o_resp_err}), 64'b10);
    chk("slow_req_busy", 64'(o_req_ready), 64'd0);
    @(negedge i_clk);
    clear_slave();
    i_resp_ready = 1'b0;
    #1 chk("slow_req_ready", 64'(o_req_ready), 64'd1);
    chk("slow_resps", 64'(mon_resps - r0), 64'd1);

    // Write len=3 with an engine gap after beat 1 and a stalled B response.
    $display("txn seq write len=3 @2000 engine gap, b stall");
    w0 = mon_w_beats;
    a0 = mon_w_lasts;
    r0 = mon_resps;
    do_req(1'b1, 32'h0000_2000, 8'd3);
    xmsti.aw_ready = 1'b1;
    @(negedge i_clk);
    xmsti.aw_ready = 1'b0;
    xmsti.w_ready  = 1'b1;
    i_wdata_valid  = 1'b1;
    i_wdata        = pat(32'h2000, 0);
    #1 chk("gap_w_last0", 64'(xmsto.w_last), 64'd0);
    @(negedge i_clk);
    i_wdata_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("gap_w_valid", 64'(xmsto.w_valid), 64'd0);
      @(negedge i_clk);
    end
    for (int b = 1; b < 4; b++) begin
      i_wdata_valid = 1'b1;
      i_wdata       = pat(32'h2000, b);
      #1;
      chk("gap_w_data", xmsto.w_data, pat(32'h2000, b));
      chk("gap_w_last", 64'(xmsto.w_last), 64'(b == 3));
      @(negedge i_clk);
    end
    i_wdata_valid = 1'b0;
    xmsti.b_valid = 1'b1;
    i_resp_ready  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bstall_b_ready", 64'(xmsto.b_ready), 64'd0);
      chk("bstall_valid", 64'(o_resp_valid), 64'd1);
      @(negedge i_clk);
    end
    i_resp_ready = 1'b1;
    #1 chk("bstall_b_ready_hi", 64'(xmsto.b_ready), 64'd1);
    @(negedge i_clk);
    clear_slave();
    i_resp_ready = 1'b0;
    #1;
    chk("gap_w_beats", 64'(mon_w_beats - w0), 64'd4);
    chk("gap_w_lasts", 64'(mon_w_lasts - a0), 64'd1);
    chk("gap_resps", 64'(mon_resps - r0), 64'd1);
    chk("gap_req_ready", 64'(o_req_ready), 64'd1);

    // Read len=3: SLVERR on beat 2, engine stalls beat 1 for 5 cycles.
    $display("txn seq read len=3 @3000 slverr beat2, r stall");
    r0 = mon_resps;
    do_req(1'b0, 32'h0000_3000, 8'd3);
    xmsti.ar_ready = 1'b1;
    @(negedge i_clk);
    xmsti.ar_ready = 1'b0;
    xmsti.r_valid  = 1'b1;
    xmsti.r_data   = pat(32'h3000, 0);
    i_resp_ready   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rstall_r_ready", 64'(xmsto.r_ready), 64'd0);
      chk("rstall_rdata", o_resp_rdata, pat(32'h3000, 0));
      @(negedge i_clk);
    end
    for (int b = 0; b < 4; b++) begin
      xmsti.r_valid = 1'b1;
      xmsti.r_data  = pat(32'h3000, b);
      xmsti.r_resp  = (b == 1) ? 2'b10 : 2'b00;
      xmsti.r_last  = (b == 3);
      i_resp_ready  = 1'b1;
      #1;
      chk("slverr_err", 64'(o_resp_err), 64'(b == 1));
      chk("slverr_last", 64'(o_resp_last), 64'(b == 3));
      chk("slverr_rdata", o_resp_rdata, pat(32'h3000, b));
      @(negedge i_clk);
    end
    clear_slave();
    i_resp_ready = 1'b0;
    #1;
    chk("slverr_resps", 64'(mon_resps - r0), 64'd4);
    chk("slverr_req_ready", 64'(o_req_ready), 64'd1);

    // Reset asserted mid write burst, then a fresh read.
    $display("txn seq write len=3 @6000 reset after beat 1");
    do_req(1'b1, 32'h0000_6000, 8'd3);
    xmsti.aw_ready = 1'b1;
    @(negedge i_clk);
    xmsti.aw_ready = 1'b0;
    xmsti.w_ready  = 1'b1;
    i_wdata_valid  = 1'b1;
    i_wdata        = pat(32'h6000, 0);
    @(negedge i_clk);
    i_wdata = pat(32'h6000, 1);
    #1 chk("mid_w_valid_pre", 64'(xmsto.w_valid), 64'd1);
    #1 i_nrst = 1'b0;
    #1;
    chk("mid_w_valid", 64'(xmsto.w_valid), 64'd0);
    chk("mid_addr_valid", 64'(xmsto.ar_valid | xmsto.aw_valid), 64'd0);
    chk("mid_wdata_ready", 64'(o_wdata_ready), 64'd0);
    chk("mid_resp_valid", 64'(o_resp_valid), 64'd0);
    @(negedge i_clk);
    i_nrst        = 1'b1;
    i_wdata_valid = 1'b0;
    clear_slave();
    #1 chk("mid_req_ready", 64'(o_req_ready), 64'd1);
    run_vec('{1'b0, 32'h0000_7000, 8'd1, 1'b0, 0, 2, 1});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/accel_axi_mst.md
Name: accel_axi_mst

Overview:
- AXI4 master bridge. Converts a simple request/stream interface from an accelerator engine into AXI4 burst transactions on one master slot of the accel bus0 interconnect.
- It is the initiator counterpart of the slave-side req/resp adapter: engines issue address/length requests, stream write beats, and receive read beats or write completion.
- One transaction in flight; INCR bursts of full bus-width beats.

Parameters:
xid, 0, AXI ID driven on ar_id/aw_id (width CFG_SYSBUS_ID_BITS)
burst_max, 16, maximum beats per request; larger i_req_len is rejected

Ports:
i_clk  in  1  bus clock
i_nrst  in  1  reset, asynchronous, active LOW
o_xmsto  out  axi4_master_out_type  AXI4 master outputs to interconnect
i_xmsti  in  axi4_master_in_type  AXI4 master inputs from interconnect
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted (IDLE only)
i_req_write  in  1  1=write, 0=read
i_req_addr  in  CFG_SYSBUS_ADDR_BITS  byte address, aligned to CFG_SYSBUS_DATA_BYTES
i_req_len  in  8  beats minus 1 (AXI len encoding)
i_wdata_valid  in  1  write beat valid
i_wdata  in  CFG_SYSBUS_DATA_BITS  write data
i_wstrb  in  CFG_SYSBUS_DATA_BYTES  write strobes
o_wdata_ready  out  1  write beat accepted
o_resp_valid  out  1  read beat / write completion valid
o_resp_rdata  out  CFG_SYSBUS_DATA_BITS  read data (all ones for writes and errors)
o_resp_last  out  1  last response of request
o_resp_err  out  1  SLVERR/DECERR or rejected request
i_resp_ready  in  1  engine accepts response

Behaviour:
- States: IDLE, AR, R, AW, W, B, ERR. Async reset -> IDLE, beat counter 0, latched addr/len/write 0.
- Reset values: all o_xmsto valid/ready bits 0, o_wdata_ready 0, o_resp_valid 0. o_req_ready=1 once IDLE after reset release.
- IDLE: o_req_ready=1. On i_req_valid, latch addr, len, write.
  - Reject -> ERR if i_req_len >= burst_max, or if addr[11:0] + (len+1)*CFG_SYSBUS_DATA_BYTES > 4096 (4 KB crossing).
  - Otherwise -> AR (read) or AW (write).
- AR/AW: assert ar_valid/aw_valid from the next cycle after accept, with:
  - addr = latched addr; len = latched len; size = log2(CFG_SYSBUS_DATA_BYTES); burst = INCR.
  - id = xid; lock/cache/prot/qos/region/user = 0.
  - Bits held stable until ar_ready/aw_ready. The handshake cycle moves to R/W.
- R: r_ready = i_resp_ready (combinational). o_resp_valid = r_valid; rdata passthrough; o_resp_last = r_last; o_resp_err = r_resp[1].
  - Beat accepted when r_valid & i_resp_ready.
  - Accepted beat with r_last -> IDLE; o_req_ready is high in the following cycle.
  - A beat error does not abort; the burst runs to r_last.
- W: w_valid = i_wdata_valid; o_wdata_ready = w_ready; w_data/w_strb passthrough; w_user 0.
  - Beat counter starts at len and decrements per accepted beat; w_last = (counter==0).
  - Last accepted beat -> B. Extra engine beats are not accepted outside W (o_wdata_ready=0).
- B: b_ready = i_resp_ready. o_resp_valid = b_valid, o_resp_last=1, o_resp_err=b_resp[1], rdata all ones.
  - b_valid & i_resp_ready -> IDLE.
- ERR: o_resp_valid=1, err=1, last=1, rdata all ones, no AXI activity. Hold until i_resp_ready -> IDLE. For a rejected write, no write beats are consumed.
- Responses with non-matching r_id/b_id are still accepted (single outstanding).
- Latency: request accept to ar_valid/aw_valid = 1 cycle. Responses are combinational passthrough (0 cycles).
- Reset mid-transaction: all valids drop asynchronously, state IDLE. Recovery of the partially served slave is outside this block.
- Simultaneous i_req_valid on the IDLE-return cycle: not accepted until IDLE is registered.

Test Plan:
- Read len=0 @0x1000; slave ar_ready after 2 cycles, returns 0x1122334455667788 OKAY -> ar_valid held 3 cycles with len=0/size=3/burst=1; one resp beat, last=1, err=0; o_req_ready back 1 cycle later.
- Write len=3 @0x2000, engine drops i_wdata_valid on beat 2 for 3 cycles -> exactly 4 W beats, w_last only on the 4th; one resp with err=0 after b_valid.
- Read len=1 @0x0FF8 -> no ar_valid; resp err=1, last=1, rdata=all ones. Write len=20 (burst_max=16) -> same, no W beats consumed.
- Read len=3 with SLVERR on beat 2 -> err=1 on beat 2 only; all 4 beats delivered; last on beat 4.
- Hold i_resp_ready=0 for 5 cycles during R and B -> r_ready/b_ready stay 0; no beat lost or duplicated.
- Assert i_nrst=0 mid write burst (after beat 1) -> all valids 0 in the same cycle; after release, IDLE with o_req_ready=1; a fresh read completes normally.
